// File: rtl/wb_read_master_pkg.sv
// Shared types and constants for the Wishbone block-read master and its output buffer.
package wb_read_master_pkg;

   localparam int unsigned FIFO_DEPTH = 2;
   localparam int unsigned FIFO_PTR_W = 1;
   localparam int unsigned FIFO_CNT_W = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REQ   = 2'd1,
      ST_GAP   = 2'd2,
      ST_DRAIN = 2'd3
   } state_e;

endpackage

// File: rtl/wb_read_fifo.sv
// Two-entry first-word-fall-through buffer between the bus side and the stream side.
module wb_read_fifo
   import wb_read_master_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic [WIDTH-1:0]      din,
   input  logic                  pop,
   output logic [WIDTH-1:0]      dout,
   output logic                  full,
   output logic                  empty,
   output logic [FIFO_CNT_W-1:0] count
);

   logic [WIDTH-1:0]      mem [FIFO_DEPTH];
   logic [FIFO_PTR_W-1:0] wr_ptr;
   logic [FIFO_PTR_W-1:0] rd_ptr;
   logic                  do_push;
   logic                  do_pop;

   assign full    = (count == FIFO_CNT_W'(FIFO_DEPTH));
   assign empty   = (count == '0);
   assign dout    = mem[rd_ptr];
   assign do_pop  = pop && !empty;
   // A push into a full buffer is accepted only when the head leaves in the same cycle.
   assign do_push = push && (!full || do_pop);

   // Pointers wrap naturally because the depth is a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
            mem[i] <= '0;
         end
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + FIFO_PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + FIFO_PTR_W'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + FIFO_CNT_W'(1);
            2'b01:   count <= count - FIFO_CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/wb_read_master.sv
// Wishbone block-read initiator streaming words out over valid/ready.
// Optional bus timeout abort is enabled by defining WB_READ_MASTER_TIMEOUT_EN.
module wb_read_master
   import wb_read_master_pkg::*;
#(
   parameter int unsigned WB_DATA_WIDTH  = 8,
   parameter int unsigned WB_ADDR_WIDTH  = 12,
   parameter int unsigned LEN_WIDTH      = 12,
   parameter int unsigned TIMEOUT_CYCLES = 15
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     start_i,
   input  logic [WB_ADDR_WIDTH-1:0] base_adr_i,
   input  logic [LEN_WIDTH-1:0]     len_i,
   output logic                     busy_o,
   output logic                     done_o,
   output logic                     err_o,
   output logic                     stb_o,
   output logic                     we_o,
   output logic [WB_ADDR_WIDTH-1:0] adr_o,
   input  logic [WB_DATA_WIDTH-1:0] dat_i,
   input  logic                     ack_i,
   output logic                     m_valid_o,
   output logic [WB_DATA_WIDTH-1:0] m_data_o,
   input  logic                     m_ready_i
);

   if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 1");
   end

   state_e                  state;
   logic [LEN_WIDTH-1:0]    remaining;
   logic                    fifo_push;
   logic                    fifo_pop;
   logic                    fifo_full;
   logic                    fifo_empty;
   logic [FIFO_CNT_W-1:0]   fifo_count;

`ifdef WB_READ_MASTER_TIMEOUT_EN
   localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TMO_W-1:0] tmo_cnt;
   logic             err_r;
   assign err_o = err_r;
`else
   assign err_o = 1'b0;
`endif

   assign we_o      = 1'b0;
   assign fifo_push = (state == ST_REQ) && ack_i;
   assign m_valid_o = !fifo_empty;
   assign fifo_pop  = m_valid_o && m_ready_i;

   wb_read_fifo #(
      .WIDTH (WB_DATA_WIDTH)
   ) u_fifo (
      .clk   (clk_i),
      .rst   (rst_i),
      .push  (fifo_push),
      .din   (dat_i),
      .pop   (fifo_pop),
      .dout  (m_data_o),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // Sequencer: one strobe at a time, a mandatory idle gap after each ack.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state     <= ST_IDLE;
         busy_o    <= 1'b0;
         done_o    <= 1'b0;
         stb_o     <= 1'b0;
         adr_o     <= '0;
         remaining <= '0;
`ifdef WB_READ_MASTER_TIMEOUT_EN
         tmo_cnt   <= '0;
         err_r     <= 1'b0;
`endif
      end else begin
         done_o <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start_i) begin
`ifdef WB_READ_MASTER_TIMEOUT_EN
                  err_r <= 1'b0;
`endif
                  if (len_i == '0) begin
                     done_o <= 1'b1;
                  end else begin
                     adr_o     <= base_adr_i;
                     remaining <= len_i;
                     busy_o    <= 1'b1;
                     stb_o     <= 1'b1;
                     state     <= ST_REQ;
`ifdef WB_READ_MASTER_TIMEOUT_EN
                     tmo_cnt   <= '0;
`endif
                  end
               end
            end
            ST_REQ: begin
               if (ack_i) begin
                  adr_o     <= adr_o + WB_ADDR_WIDTH'(1);
                  remaining <= remaining - LEN_WIDTH'(1);
                  stb_o     <= 1'b0;
                  state     <= ST_GAP;
               end
`ifdef WB_READ_MASTER_TIMEOUT_EN
               // Abandon the rest of the block; buffered words still drain.
               else if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                  stb_o <= 1'b0;
                  err_r <= 1'b1;
                  state <= ST_DRAIN;
               end else begin
                  tmo_cnt <= tmo_cnt + TMO_W'(1);
               end
`endif
            end
            ST_GAP: begin
               if (remaining == '0) begin
                  state <= ST_DRAIN;
               end else if (!fifo_full) begin
                  stb_o <= 1'b1;
                  state <= ST_REQ;
`ifdef WB_READ_MASTER_TIMEOUT_EN
                  tmo_cnt <= '0;
`endif
               end
            end
            ST_DRAIN: begin
               if (fifo_count == '0) begin
                  done_o <= 1'b1;
                  busy_o <= 1'b0;
                  state  <= ST_IDLE;
               end
            end
            default: begin
               stb_o <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wb_read_master.sv
// Directed bench for wb_read_master with a one-cycle-latency responder (dat = adr[7:0] ^ 8'hA5).
module tb_wb_read_master;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [11:0] base_adr = '0;
   logic [11:0] len = '0;
   logic        busy, done, err, stb, we;
   logic [11:0] adr;
   logic [7:0]  dat;
   logic        ack;
   logic        m_valid;
   logic [7:0]  m_data;
   logic        m_ready = 1'b0;
   logic        ack_en = 1'b1;

   int checks = 0;
   int errors = 0;

   logic [7:0]  got[$];
   logic [11:0] adrs[$];
   int          rise_cyc[$];
   int          cyc = 0;
   int          done_cnt = 0;
   int          stb_hi_cnt = 0;
   logic        stb_prev = 1'b0;
   logic        busy_prev = 1'b0;
   logic        busy_at_done = 1'b0;
   logic        busy_before_done = 1'b0;

   wb_read_master dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .start_i    (start),
      .base_adr_i (base_adr),
      .len_i      (len),
      .busy_o     (busy),
      .done_o     (done),
      .err_o      (err),
      .stb_o      (stb),
      .we_o       (we),
      .adr_o      (adr),
      .dat_i      (dat),
      .ack_i      (ack),
      .m_valid_o  (m_valid),
      .m_data_o   (m_data),
      .m_ready_i  (m_ready)
   );

   always #5 clk = ~clk;

   // Responder: acks one cycle after strobe, never two acks back to back.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         ack <= 1'b0;
         dat <= '0;
      end else begin
         ack <= stb && !ack && ack_en;
         dat <= adr[7:0] ^ 8'hA5;
      end
   end

   // Monitor: stream beats, strobe starts, done pulses.
   always @(posedge clk) begin
      cyc = cyc + 1;
      if (m_valid && m_ready) got.push_back(m_data);
      if (stb) stb_hi_cnt = stb_hi_cnt + 1;
      if (stb && !stb_prev) begin
         adrs.push_back(adr);
         rise_cyc.push_back(cyc);
      end
      if (done) begin
         done_cnt = done_cnt + 1;
         busy_at_done = busy;
         busy_before_done = busy_prev;
      end
      stb_prev = stb;
      busy_prev = busy;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_mon();
      got.delete();
      adrs.delete();
      rise_cyc.delete();
      stb_hi_cnt = 0;
   endtask

   task automatic do_start(input logic [11:0] b, input logic [11:0] l);
      start = 1'b1;
      base_adr = b;
      len = l;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget, input int d0, input string tag);
      int n = 0;
      while (done_cnt == d0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 32'(done_cnt != d0), 32'd1);
   endtask

   initial begin
      int d0;

      // Reset values while reset is held across clock edges
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_stb", 32'(stb), 32'd0);
      chk("rst_we", 32'(we), 32'd0);
      chk("rst_mvalid", 32'(m_valid), 32'd0);
      chk("rst_adr", 32'(adr), 32'd0);
      chk("rst_mdata", 32'(m_data), 32'd0);
      rst = 1'b0;
      clear_mon();
      repeat (20) @(negedge clk);
      chk("idle_no_stb", 32'(stb_hi_cnt), 32'd0);

      // Basic read of four words
      m_ready = 1'b1;
      clear_mon();
      d0 = done_cnt;
      do_start(12'h010, 12'd4);
      wait_done(100, d0, "basic_done_seen");
      repeat (5) @(negedge clk);
      chk("basic_words", 32'(got.size()), 32'd4);
      if (got.size() == 4) begin
         chk("basic_w0", 32'(got[0]), 32'hB5);
         chk("basic_w1", 32'(got[1]), 32'hB4);
         chk("basic_w2", 32'(got[2]), 32'hB7);
         chk("basic_w3", 32'(got[3]), 32'hB6);
      end
      chk("basic_strobes", 32'(adrs.size()), 32'd4);
      if (adrs.size() == 4) begin
         chk("basic_adr0", 32'(adrs[0]), 32'h010);
         chk("basic_adr3", 32'(adrs[3]), 32'h013);
         for (int i = 0; i < 3; i++)
            chk("basic_spacing", 32'(rise_cyc[i+1] - rise_cyc[i]), 32'd3);
      end
      chk("basic_done_once", 32'(done_cnt - d0), 32'd1);
      chk("basic_busy_at_done", 32'(busy_at_done), 32'd0);
      chk("basic_busy_before_done", 32'(busy_before_done), 32'd1);
      chk("basic_busy_after", 32'(busy), 32'd0);

      // Backpressure with address wrap
      m_ready = 1'b0;
      clear_mon();
      d0 = done_cnt;
      do_start(12'hFFE, 12'd4);
      repeat (30) @(negedge clk);
      chk("bp_strobes", 32'(adrs.size()), 32'd2);
      if (adrs.size() == 2) begin
         chk("bp_adr0", 32'(adrs[0]), 32'hFFE);
         chk("bp_adr1", 32'(adrs[1]), 32'hFFF);
      end
      chk("bp_stb_held", 32'(stb), 32'd0);
      chk("bp_mvalid", 32'(m_valid), 32'd1);
      chk("bp_head", 32'(m_data), 32'h5B);
      chk("bp_busy", 32'(busy), 32'd1);
      chk("bp_no_done", 32'(done_cnt - d0), 32'd0);
      m_ready = 1'b1;
      wait_done(100, d0, "bp_done_seen");
      repeat (3) @(negedge clk);
      chk("bp_words", 32'(got.size()), 32'd4);
      if (got.size() == 4) begin
         chk("bp_w0", 32'(got[0]), 32'h5B);
         chk("bp_w1", 32'(got[1]), 32'h5A);
         chk("bp_w2", 32'(got[2]), 32'hA5);
         chk("bp_w3", 32'(got[3]), 32'hA4);
      end
      chk("bp_strobes_total", 32'(adrs.size()), 32'd4);
      if (adrs.size() == 4) begin
         chk("bp_adr2_wrap", 32'(adrs[2]), 32'h000);
         chk("bp_adr3", 32'(adrs[3]), 32'h001);
      end

      // Zero length
      clear_mon();
      d0 = done_cnt;
      start = 1'b1;
      base_adr = 12'h123;
      len = 12'd0;
      @(negedge clk);
      start = 1'b0;
      chk("zero_done_pulse", 32'(done), 32'd1);
      chk("zero_busy", 32'(busy), 32'd0);
      @(negedge clk);
      chk("zero_done_cleared", 32'(done), 32'd0);
      repeat (5) @(negedge clk);
      chk("zero_no_stb", 32'(stb_hi_cnt), 32'd0);
      chk("zero_done_once", 32'(done_cnt - d0), 32'd1);

`ifdef WB_READ_MASTER_TIMEOUT_EN
      // Responder never acks
      ack_en = 1'b0;
      clear_mon();
      d0 = done_cnt;
      do_start(12'h040, 12'd3);
      wait_done(100, d0, "tmo_done_seen");
      repeat (3) @(negedge clk);
      chk("tmo_stb_cycles", 32'(stb_hi_cnt), 32'd15);
      chk("tmo_strobes", 32'(adrs.size()), 32'd1);
      chk("tmo_err", 32'(err), 32'd1);
      chk("tmo_no_data", 32'(got.size()), 32'd0);
      chk("tmo_done_once", 32'(done_cnt - d0), 32'd1);
      ack_en = 1'b1;
      clear_mon();
      d0 = done_cnt;
      do_start(12'h020, 12'd1);
      chk("tmo_err_cleared", 32'(err), 32'd0);
      wait_done(100, d0, "tmo_next_done_seen");
      repeat (2) @(negedge clk);
      chk("tmo_next_words", 32'(got.size()), 32'd1);
      if (got.size() == 1) chk("tmo_next_w0", 32'(got[0]), 32'h85);
`else
      chk("err_tied_low", 32'(err), 32'd0);
`endif

      // Reset in the middle of a transfer
      m_ready = 1'b0;
      clear_mon();
      begin
         int n = 0;
         do_start(12'h100, 12'd8);
         while (!(stb && m_valid) && n < 50) begin
            @(negedge clk);
            n++;
         end
         chk("mid_reached_stb", 32'(stb && m_valid), 32'd1);
      end
      d0 = done_cnt;
      #2 rst = 1'b1;
      #1;
      chk("mid_stb_async", 32'(stb), 32'd0);
      chk("mid_mvalid_async", 32'(m_valid), 32'd0);
      chk("mid_busy_async", 32'(busy), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      chk("mid_no_done", 32'(done_cnt - d0), 32'd0);
      chk("mid_idle_stb", 32'(stb), 32'd0);
      m_ready = 1'b1;
      clear_mon();
      do_start(12'h030, 12'd2);
      wait_done(100, d0, "mid_fresh_done_seen");
      repeat (3) @(negedge clk);
      chk("mid_fresh_words", 32'(got.size()), 32'd2);
      if (got.size() == 2) begin
         chk("mid_fresh_w0", 32'(got[0]), 32'h95);
         chk("mid_fresh_w1", 32'(got[1]), 32'h94);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
